// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data RAM (async read, sync write) between the CPU
//   data port and an auxiliary requester (debug loader / DMA).
//
//   Arbitration:
//     - The CPU has priority. The aux side only gets the RAM in idle CPU
//       cycles, unless it has been denied STARVE_MAX consecutive cycles.
//       In that case a forced aux slot is taken and the CPU is stalled.
//     - A forced slot may be extended into a locked burst with aux_lock.
//       The burst is capped at LOCK_MAX grants.
//
//   Optional build macro:
//     DMEM_ARB_PERF_EN  builds saturating performance counters.
//                       When undefined, the perf ports are tied to 0.
//
//   Ports:
//     fpga_clk, fpga_rst    clock and reset (reset is asynchronous, active-high)
//     cpu_req/we/addr/wdata CPU data port request
//     cpu_rdata             CPU load data (RAM read data, combinational)
//     cpu_stall             CPU access not performed this cycle
//     aux_req/we/lock/addr/wdata
//                           aux request; held stable until aux_gnt
//     aux_gnt               aux access performed this cycle (combinational)
//     aux_ack, aux_rdata    registered completion one cycle after aux_gnt
//     dmem_addr/we/wdata    to the RAM
//     dmem_rdata            RAM read data (spo)
//     perf_stall_cnt        CPU stall cycles
//     perf_aux_cnt          aux transfers
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int LOCK_MAX   = 16
) (
  input  logic              fpga_clk,
  input  logic              fpga_rst,
  // CPU data port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // aux requester
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic              aux_lock,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  // RAM port
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  // performance counters
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_aux_cnt
);

  // Sized so that STARVE_MAX/LOCK_MAX = 1 still yields a 1-bit counter.
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  localparam int LOCK_W = $clog2(LOCK_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_MAX - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MAX - 1);

  typedef enum logic {
    ST_CPU = 1'b0,   // CPU priority, aux only in idle CPU cycles
    ST_AUX = 1'b1    // forced aux slot / locked burst, CPU stalled
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              aux_ack_q;
  logic [DATA_W-1:0] aux_rdata_q;

  logic              gnt;
  logic              stall;
  logic              cpu_own;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      state_q    <= ST_CPU;
      wait_cnt_q <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_CPU: begin
        // aux_lock is deliberately ignored here.
        // Locked bursts only start from a forced slot.
        if (gnt || !aux_req) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // This is the STARVE_MAX-th denied cycle; force an aux slot next.
          state_d    = ST_AUX;
          wait_cnt_d = '0;
          lock_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_AUX: begin
        // Leave when the requester drops, the burst is not locked, or the
        // cap is reached. The grant in this cycle still completes.
        if (!aux_req || !aux_lock || lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_CPU;
          wait_cnt_d = '0;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: state_d = ST_CPU;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    gnt   = 1'b0;
    stall = 1'b0;
    // Gated by reset: a request pending during reset is dropped, not granted.
    if (!fpga_rst) begin
      case (state_q)
        ST_CPU: gnt = aux_req & ~cpu_req;
        ST_AUX: begin
          gnt   = aux_req;
          stall = cpu_req & aux_req;
        end
        default: ;
      endcase
    end
    // The CPU performs its access whenever the aux side is not granted.
    // A stall always coincides with a grant.
    cpu_own = cpu_req & ~gnt;
  end

  // RAM mux.
  // With no owner, the address follows the CPU and nothing is written.
  // A stalled CPU store never reaches the RAM.
  assign dmem_addr  = gnt ? aux_addr  : cpu_addr;
  assign dmem_wdata = gnt ? aux_wdata : cpu_wdata;
  assign dmem_we    = ~fpga_rst & (gnt ? aux_we : (cpu_own & cpu_we));

  assign cpu_rdata  = dmem_rdata;
  assign cpu_stall  = stall;
  assign aux_gnt    = gnt;

  // -------------------------------------------------------------------------
  // Aux completion: one-cycle ack.
  // Read data is captured only for reads; writes leave it unchanged.
  // -------------------------------------------------------------------------
  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      aux_ack_q <= gnt;
      if (gnt && !aux_we) aux_rdata_q <= dmem_rdata;
    end
  end

  assign aux_ack   = aux_ack_q;
  assign aux_rdata = aux_rdata_q;

  // -------------------------------------------------------------------------
  // Performance counters (saturating)
  // -------------------------------------------------------------------------
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] aux_cnt_q, aux_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    aux_cnt_d   = aux_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
    if (gnt   && aux_cnt_q   != 32'hFFFF_FFFF) aux_cnt_d   = aux_cnt_q + 32'd1;
  end

  always_ff @(posedge fpga_clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      stall_cnt_q <= '0;
      aux_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      aux_cnt_q   <= aux_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_aux_cnt   = aux_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_aux_cnt   = 32'd0;
`endif

endmodule
